// File: rtl/rr_mux2_pkg.sv
// Shared types for the two-input round-robin stream merger.
// The select encoding matches the 1-to-2 demux, so out_sel can steer it directly.
package rr_mux2_pkg;

   typedef enum logic {
      SEL_IN1 = 1'b0,
      SEL_IN2 = 1'b1
   } sel_t;

   // Starting with in2 as "last served" makes in1 win the first tie after reset.
   localparam sel_t SEL_RESET = SEL_IN2;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
// Priority only rotates when a grant is actually taken (advance), never on idle cycles.
module rr_arb2
   import rr_mux2_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req1,
   input  logic req2,
   input  logic advance,
   output logic gnt1,
   output logic gnt2
);

   sel_t last_sel;

   // A lone requester always wins; on a tie the one not served last wins.
   always_comb begin
      gnt1 = req1 && (!req2 || (last_sel == SEL_IN2));
      gnt2 = req2 && (!req1 || (last_sel == SEL_IN1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_sel <= SEL_RESET;
      end else if (advance) begin
         last_sel <= gnt2 ? SEL_IN2 : SEL_IN1;
      end
   end

endmodule

// File: rtl/rr_mux2.sv
// Merges two valid/ready streams onto one registered output, tagged with its source.
// Ready is combinational so a stalled output register drains and reloads on the same edge.
module rr_mux2
   import rr_mux2_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in1_valid,
   output logic             in1_ready,
   input  logic [WIDTH-1:0] in1_data,
   input  logic             in2_valid,
   output logic             in2_ready,
   input  logic [WIDTH-1:0] in2_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_sel
);

   logic load;
   logic gnt1;
   logic gnt2;
   sel_t sel_q;

   assign load      = !out_valid || out_ready;
   assign in1_ready = load && gnt1 && !rst;
   assign in2_ready = load && gnt2 && !rst;
   assign out_sel   = sel_q;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req1    (in1_valid),
      .req2    (in2_valid),
      .advance (in1_ready || in2_ready),
      .gnt1    (gnt1),
      .gnt2    (gnt2)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         sel_q     <= SEL_IN1;
      end else if (in1_ready) begin
         out_valid <= 1'b1;
         out_data  <= in1_data;
         sel_q     <= SEL_IN1;
      end else if (in2_ready) begin
         out_valid <= 1'b1;
         out_data  <= in2_data;
         sel_q     <= SEL_IN2;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_mux2.sv
// Bench for rr_mux2: a hand-computed vector table for the directed corners, then
// random traffic checked by a reference model and an in-order delivery scoreboard.
module tb_rr_mux2;

   logic       clk;
   logic       rst;
   logic       in1_valid;
   logic       in1_ready;
   logic [7:0] in1_data;
   logic       in2_valid;
   logic       in2_ready;
   logic [7:0] in2_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_sel;

   rr_mux2 #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in1_valid (in1_valid),
      .in1_ready (in1_ready),
      .in1_data  (in1_data),
      .in2_valid (in2_valid),
      .in2_ready (in2_ready),
      .in2_data  (in2_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state (pre-edge view)
   bit         m_ov   = 1'b0;
   bit         m_last = 1'b1;
   logic [8:0] sb_q[$];
   bit         acc1, acc2;
   logic       s_r1, s_r2;
   int         wait1 = 0;
   int         wait2 = 0;

   task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive, check readies and drained word, update model, step past the edge.
   task automatic cycle(input bit r, input bit v1, input logic [7:0] d1,
                        input bit v2, input logic [7:0] d2, input bit ordy);
      bit load, g1, g2, e1, e2;
      logic [8:0] exp_w;
      rst = r; in1_valid = v1; in1_data = d1;
      in2_valid = v2; in2_data = d2; out_ready = ordy;
      #2;
      load = !m_ov || ordy;
      g1 = v1 && (!v2 || m_last == 1'b1);
      g2 = v2 && (!v1 || m_last == 1'b0);
      e1 = load && g1 && !r;
      e2 = load && g2 && !r;
      s_r1 = in1_ready;
      s_r2 = in2_ready;
      chk("in1_ready", {8'h0, in1_ready}, {8'h0, e1});
      chk("in2_ready", {8'h0, in2_ready}, {8'h0, e2});
      chk("out_valid", {8'h0, out_valid}, {8'h0, m_ov});
      if (!r && out_valid && ordy) begin
         if (sb_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL delivery: got %0h with nothing outstanding", {out_sel, out_data});
         end else begin
            exp_w = sb_q.pop_front();
            chk("delivered_word", {out_sel, out_data}, exp_w);
         end
      end
      // a waiting producer may see the other side served at most once
      if (v1 && in2_ready) begin wait1++; chk("in1_starve", (wait1 > 1) ? 9'h1 : 9'h0, 9'h0); end
      if (v2 && in1_ready) begin wait2++; chk("in2_starve", (wait2 > 1) ? 9'h1 : 9'h0, 9'h0); end
      if (in1_ready || !v1) wait1 = 0;
      if (in2_ready || !v2) wait2 = 0;
      if (r) begin
         m_ov = 1'b0; m_last = 1'b1; sb_q.delete();
      end else if (e1) begin
         sb_q.push_back({1'b0, d1}); m_ov = 1'b1; m_last = 1'b0;
      end else if (e2) begin
         sb_q.push_back({1'b1, d2}); m_ov = 1'b1; m_last = 1'b1;
      end else if (ordy) begin
         m_ov = 1'b0;
      end
      acc1 = e1;
      acc2 = e2;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit         r;
      bit         v1;
      logic [7:0] d1;
      bit         v2;
      logic [7:0] d2;
      bit         ordy;
      bit         x_r1;
      bit         x_r2;
      bit         x_ov;
      bit         chk_d;
      logic [7:0] x_od;
      bit         x_os;
   } vec_t;

   vec_t tbl[24];

   bit         p1_v, p2_v;
   logic [6:0] p1_cnt, p2_cnt;

   initial begin
      //          r  v1 d1     v2 d2     ordy r1 r2 ov chk od     os
      tbl[0]  = '{1, 1, 8'h99, 1, 8'h98, 1,   0, 0, 0, 1, 8'h00, 0};
      tbl[1]  = '{1, 0, 8'h00, 0, 8'h00, 1,   0, 0, 0, 1, 8'h00, 0};
      tbl[2]  = '{0, 0, 8'h00, 0, 8'h00, 0,   0, 0, 0, 1, 8'h00, 0};
      tbl[3]  = '{0, 1, 8'h11, 0, 8'h00, 1,   1, 0, 1, 1, 8'h11, 0};
      tbl[4]  = '{0, 1, 8'h22, 0, 8'h00, 1,   1, 0, 1, 1, 8'h22, 0};
      tbl[5]  = '{0, 1, 8'h33, 0, 8'h00, 1,   1, 0, 1, 1, 8'h33, 0};
      tbl[6]  = '{0, 0, 8'h00, 0, 8'h00, 1,   0, 0, 0, 0, 8'h00, 0};
      tbl[7]  = '{1, 0, 8'h00, 0, 8'h00, 1,   0, 0, 0, 1, 8'h00, 0};
      tbl[8]  = '{0, 1, 8'hA0, 1, 8'hB0, 1,   1, 0, 1, 1, 8'hA0, 0};
      tbl[9]  = '{0, 1, 8'hA1, 1, 8'hB0, 1,   0, 1, 1, 1, 8'hB0, 1};
      tbl[10] = '{0, 1, 8'hA1, 1, 8'hB1, 1,   1, 0, 1, 1, 8'hA1, 0};
      tbl[11] = '{0, 1, 8'hA2, 1, 8'hB1, 1,   0, 1, 1, 1, 8'hB1, 1};
      tbl[12] = '{0, 1, 8'h5C, 0, 8'h00, 1,   1, 0, 1, 1, 8'h5C, 0};
      tbl[13] = '{0, 1, 8'h5D, 1, 8'hB2, 0,   0, 0, 1, 1, 8'h5C, 0};
      tbl[14] = '{0, 1, 8'h5D, 1, 8'hB2, 0,   0, 0, 1, 1, 8'h5C, 0};
      tbl[15] = '{0, 1, 8'h5D, 1, 8'hB2, 0,   0, 0, 1, 1, 8'h5C, 0};
      tbl[16] = '{0, 1, 8'h5D, 1, 8'hB2, 1,   0, 1, 1, 1, 8'hB2, 1};
      tbl[17] = '{0, 1, 8'h5D, 0, 8'h00, 1,   1, 0, 1, 1, 8'h5D, 0};
      tbl[18] = '{0, 0, 8'h00, 0, 8'h00, 1,   0, 0, 0, 0, 8'h00, 0};
      tbl[19] = '{0, 0, 8'h00, 1, 8'hC0, 1,   0, 1, 1, 1, 8'hC0, 1};
      tbl[20] = '{1, 0, 8'h00, 0, 8'h00, 0,   0, 0, 0, 1, 8'h00, 0};
      tbl[21] = '{0, 1, 8'hE1, 1, 8'hE2, 0,   1, 0, 1, 1, 8'hE1, 0};
      tbl[22] = '{0, 1, 8'hE3, 1, 8'hE2, 1,   0, 1, 1, 1, 8'hE2, 1};
      tbl[23] = '{0, 0, 8'h00, 0, 8'h00, 1,   0, 0, 0, 0, 8'h00, 0};

      rst = 1'b1; in1_valid = 1'b0; in1_data = '0;
      in2_valid = 1'b0; in2_data = '0; out_ready = 1'b0;

      for (int i = 0; i < 24; i++) begin
         cycle(tbl[i].r, tbl[i].v1, tbl[i].d1, tbl[i].v2, tbl[i].d2, tbl[i].ordy);
         chk($sformatf("vec%0d_in1_ready", i), {8'h0, s_r1}, {8'h0, tbl[i].x_r1});
         chk($sformatf("vec%0d_in2_ready", i), {8'h0, s_r2}, {8'h0, tbl[i].x_r2});
         chk($sformatf("vec%0d_out_valid", i), {8'h0, out_valid}, {8'h0, tbl[i].x_ov});
         if (tbl[i].chk_d) begin
            chk($sformatf("vec%0d_out_data", i), {1'b0, out_data}, {1'b0, tbl[i].x_od});
            chk($sformatf("vec%0d_out_sel", i), {8'h0, out_sel}, {8'h0, tbl[i].x_os});
         end
      end

      // random stress: producers hold valid and data until accepted
      p1_v = 0; p2_v = 0; p1_cnt = '0; p2_cnt = '0;
      for (int c = 0; c < 600; c++) begin
         if (!p1_v) p1_v = ($urandom_range(0, 2) != 0);
         if (!p2_v) p2_v = ($urandom_range(0, 2) != 0);
         cycle(1'b0, p1_v, {1'b0, p1_cnt}, p2_v, {1'b1, p2_cnt},
               ($urandom_range(0, 3) != 0));
         if (acc1) begin p1_v = 0; p1_cnt++; end
         if (acc2) begin p2_v = 0; p2_cnt++; end
      end

      for (int c = 0; c < 4; c++) cycle(1'b0, 0, 8'h00, 0, 8'h00, 1'b1);
      chk("scoreboard_drained", sb_q.size(), 9'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
